// File: rtl/seq_pkg.sv
// Shared phase encoding for the phase sequencer and consumers of its state output.
package seq_pkg;

    localparam int unsigned PHASE_W = 2;

    localparam logic [PHASE_W-1:0] PH_IDLE  = 2'd0;
    localparam logic [PHASE_W-1:0] PH_START = 2'd1;
    localparam logic [PHASE_W-1:0] PH_RUN   = 2'd2;
    localparam logic [PHASE_W-1:0] PH_STOP  = 2'd3;

    typedef enum logic [PHASE_W-1:0] {
        IDLE  = PH_IDLE,
        START = PH_START,
        RUN   = PH_RUN,
        STOP  = PH_STOP
    } phase_e;

endpackage

// File: rtl/phase_counter.sv
// Per-phase cycle counter with a terminal-count flag; the owner muxes the terminal value.
module phase_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             last_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over increment so a phase change always restarts at 0.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign last_c = (count_q == terminal);

endmodule

// File: rtl/phase_sequencer.sv
// Four-phase sequencer IDLE -> START -> RUN -> STOP with counted dwell, abort and auto-repeat.
module phase_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned STOP_CYCLES  = 2,
    parameter int unsigned ITER_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  run_len,
    input  logic              repeat_en,
    output logic [1:0]        state,
    output logic              busy,
    output logic [CNT_W-1:0]  phase_cnt,
    output logic              done,
    output logic              aborted,
    output logic [ITER_W-1:0] iter_count
);

    localparam int unsigned     CNT_MAX    = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] START_TERM = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] STOP_TERM  = CNT_W'(STOP_CYCLES - 1);

    // Reject dwell parameters the counter cannot represent.
    if (START_CYCLES < 1 || START_CYCLES > CNT_MAX) begin : g_bad_start_cycles
        $error("phase_sequencer: START_CYCLES out of range 1..2^CNT_W-1");
    end
    if (STOP_CYCLES < 1 || STOP_CYCLES > CNT_MAX) begin : g_bad_stop_cycles
        $error("phase_sequencer: STOP_CYCLES out of range 1..2^CNT_W-1");
    end

    phase_e              state_q,   state_d;
    logic [CNT_W-1:0]    len_q,     len_d;
    logic                abort_q,   abort_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                aborted_q, aborted_d;
    logic [ITER_W-1:0]   iter_q,    iter_d;

    logic                cnt_clear_c;
    logic                cnt_en_c;
    logic [CNT_W-1:0]    cnt_term_c;
    logic                cnt_last_c;
    logic [CNT_W-1:0]    cnt_value;

    phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear_c),
        .enable   (cnt_en_c),
        .terminal (cnt_term_c),
        .count    (cnt_value),
        .last_c   (cnt_last_c)
    );

    // Next-state, counter control and completion outputs.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        abort_d     = abort_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        iter_d      = iter_q;
        cnt_clear_c = 1'b0;
        cnt_en_c    = 1'b1;
        cnt_term_c  = '0;

        case (state_q)
            IDLE: begin
                cnt_clear_c = 1'b1;
                cnt_en_c    = 1'b0;
                if (start && !abort) begin
                    state_d = START;
                    len_d   = (run_len == '0) ? CNT_W'(1) : run_len;
                    abort_d = 1'b0;
                end
            end
            START: begin
                cnt_term_c = START_TERM;
                if (abort) begin
                    state_d     = STOP;
                    abort_d     = 1'b1;
                    cnt_clear_c = 1'b1;
                end else if (cnt_last_c) begin
                    state_d     = RUN;
                    cnt_clear_c = 1'b1;
                end
            end
            RUN: begin
                cnt_term_c = len_q - CNT_W'(1);
                if (abort) begin
                    state_d     = STOP;
                    abort_d     = 1'b1;
                    cnt_clear_c = 1'b1;
                end else if (cnt_last_c) begin
                    state_d     = STOP;
                    cnt_clear_c = 1'b1;
                end
            end
            STOP: begin
                cnt_term_c = STOP_TERM;
                if (cnt_last_c) begin
                    cnt_clear_c = 1'b1;
                    done_d      = 1'b1;
                    aborted_d   = abort_q;
                    if (iter_q != {ITER_W{1'b1}}) begin
                        iter_d = iter_q + ITER_W'(1);
                    end
                    state_d = (repeat_en && !abort_q) ? START : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            iter_q    <= iter_d;
        end
    end

    assign state      = state_q;
    assign busy       = busy_q;
    assign phase_cnt  = cnt_value;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: per-cycle expected traces built from hand-derived tables.
module tb_phase_sequencer;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ITER_W = 2;

    logic              clock;
    logic              reset;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  run_len;
    logic              repeat_en;
    logic [1:0]        state;
    logic              busy;
    logic [CNT_W-1:0]  phase_cnt;
    logic              done;
    logic              aborted;
    logic [ITER_W-1:0] iter_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected trace, one entry per cycle, plus start/abort to drive in that cycle.
    int q_st[$];
    int q_pc[$];
    int q_dn[$];
    int q_ab[$];
    int q_it[$];
    int q_s[$];
    int q_a[$];

    // Default-parameter nominal trace with run_len=3, starting at cycle 1.
    int nom_st[9] = '{1, 1, 2, 2, 2, 3, 3, 0, 0};
    int nom_pc[9] = '{0, 1, 0, 1, 2, 0, 1, 0, 0};
    int rep_st[5] = '{1, 1, 2, 3, 3};
    int rep_pc[5] = '{0, 1, 0, 0, 1};

    phase_sequencer #(
        .CNT_W        (CNT_W),
        .START_CYCLES (2),
        .STOP_CYCLES  (2),
        .ITER_W       (ITER_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .run_len    (run_len),
        .repeat_en  (repeat_en),
        .state      (state),
        .busy       (busy),
        .phase_cnt  (phase_cnt),
        .done       (done),
        .aborted    (aborted),
        .iter_count (iter_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input int st, input int pc, input int dn, input int ab,
                       input int it, input int s, input int a);
        q_st.push_back(st);
        q_pc.push_back(pc);
        q_dn.push_back(dn);
        q_ab.push_back(ab);
        q_it.push_back(it);
        q_s.push_back(s);
        q_a.push_back(a);
    endtask

    // Nominal trace; optionally pokes start in cycles 1,3,5,7 where it must be ignored.
    task automatic add_nominal(input int it0, input bit poke);
        for (int i = 0; i < 9; i++) begin
            add(nom_st[i], nom_pc[i], (i == 7) ? 1 : 0, 0, (i >= 7) ? it0 + 1 : it0,
                (poke && (i % 2 == 0) && i < 7) ? 1 : 0, 0);
        end
    endtask

    task automatic verify(input string tag);
        for (int i = 0; i < q_st.size(); i++) begin
            check($sformatf("%s_c%0d_state", tag, i + 1), 32'(state), 32'(q_st[i]));
            check($sformatf("%s_c%0d_cnt", tag, i + 1), 32'(phase_cnt), 32'(q_pc[i]));
            check($sformatf("%s_c%0d_busy", tag, i + 1), 32'(busy), (q_st[i] != 0) ? 32'd1 : 32'd0);
            check($sformatf("%s_c%0d_done", tag, i + 1), 32'(done), 32'(q_dn[i]));
            check($sformatf("%s_c%0d_aborted", tag, i + 1), 32'(aborted), 32'(q_ab[i]));
            check($sformatf("%s_c%0d_iter", tag, i + 1), 32'(iter_count), 32'(q_it[i]));
            start = q_s[i][0];
            abort = q_a[i][0];
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        q_st.delete(); q_pc.delete(); q_dn.delete(); q_ab.delete();
        q_it.delete(); q_s.delete();  q_a.delete();
    endtask

    task automatic check_idle(input string tag, input int it);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cnt"}, 32'(phase_cnt), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_aborted"}, 32'(aborted), 32'd0);
        check({tag, "_iter"}, 32'(iter_count), 32'(it));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic launch(input int len);
        run_len = CNT_W'(len);
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        run_len   = '0;
        repeat_en = 1'b0;
        do_reset();
        check_idle("reset", 0);

        // Nominal sequence.
        launch(3);
        add_nominal(0, 1'b0);
        verify("nominal");

        // Zero run length behaves as one RUN cycle.
        launch(0);
        for (int i = 0; i < 6; i++) begin
            add(rep_st[i % 5] * ((i < 5) ? 1 : 0), (i < 5) ? rep_pc[i] : 0,
                (i == 5) ? 1 : 0, 0, (i == 5) ? 2 : 1, 0, 0);
        end
        verify("zerolen");

        // Abort in second RUN cycle with repeat_en held high.
        repeat_en = 1'b1;
        launch(10);
        add(1, 0, 0, 0, 2, 0, 0);
        add(1, 1, 0, 0, 2, 0, 0);
        add(2, 0, 0, 0, 2, 0, 0);
        add(2, 1, 0, 0, 2, 0, 1);
        add(3, 0, 0, 0, 2, 0, 0);
        add(3, 1, 0, 0, 2, 0, 0);
        add(0, 0, 1, 1, 3, 0, 0);
        add(0, 0, 0, 0, 3, 0, 0);
        verify("abort");
        repeat_en = 1'b0;

        // Ignored starts while busy and run_len change mid-sequence.
        do_reset();
        check_idle("reset2", 0);
        launch(3);
        run_len = '0;
        add_nominal(0, 1'b1);
        verify("ignored");

        // start together with abort in IDLE is dropped.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_idle("startabort_a", 1);
        step();
        check_idle("startabort_b", 1);

        // Reset in the middle of RUN.
        launch(3);
        for (int i = 0; i < 3; i++) begin
            add(nom_st[i], nom_pc[i], 0, 0, 1, 0, 0);
        end
        verify("prereset");
        check("midrun_state", 32'(state), 32'd2);
        check("midrun_cnt", 32'(phase_cnt), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("midrun_reset", 0);
        step();
        check_idle("midrun_after", 0);
        launch(3);
        add_nominal(0, 1'b0);
        verify("fresh");

        // Auto-repeat with saturating iteration count, then drop repeat_en.
        do_reset();
        repeat_en = 1'b1;
        launch(1);
        for (int c = 1; c <= 20; c++) begin
            add(rep_st[(c - 1) % 5], rep_pc[(c - 1) % 5],
                (c > 1 && (c - 1) % 5 == 0) ? 1 : 0, 0,
                ((c - 1) / 5 > 3) ? 3 : (c - 1) / 5, 0, 0);
        end
        verify("repeat");
        repeat_en = 1'b0;
        for (int c = 21; c <= 25; c++) begin
            add(rep_st[(c - 1) % 5], rep_pc[(c - 1) % 5], (c == 21) ? 1 : 0, 0, 3, 0, 0);
        end
        add(0, 0, 1, 0, 3, 0, 0);
        add(0, 0, 0, 0, 3, 0, 0);
        verify("repeat_end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
